// File: rtl/instr_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// edusoc_fetch_pkg
//   Shared types and constants for the instruction prefetch unit.
//   - fetch_state_t : prefetch controller states
//   - XLEN          : address / instruction width
//   - FETCH_STEP    : byte distance between sequential instruction words
//   - fetch_entry_t : one buffered instruction with the PC it was fetched from
// -----------------------------------------------------------------------------
package edusoc_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] FETCH_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    FAULT   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
//   Synchronous FIFO of fetch_entry_t used as the prefetch buffer. Flush has
//   priority over push and pop. The head entry is read straight from the
//   storage registers, so it carries no combinational input dependency.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     push_i, data_i : write data_i at the tail
//     pop_i          : drop the head entry (caller guarantees non-empty)
//     flush_i        : empty the FIFO
//     count_o        : number of valid entries (0..DEPTH)
//     head_o         : oldest entry
//
// prefetch_fifo_chk
//   Simulation checker: a push into a full FIFO must never happen.
// -----------------------------------------------------------------------------
module prefetch_fifo
  import edusoc_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  fetch_entry_t                   data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [$clog2(DEPTH):0]         count_o,
  output fetch_entry_t                   head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Entry storage; contents need no reset because count_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  prefetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_i),
    .flush_i (flush_i),
    .count_i (count_q)
  );

endmodule

module prefetch_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic                   push_i,
  input logic                   flush_i,
  input logic [$clog2(DEPTH):0] count_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (push_i && !flush_i) |-> (count_i < CW'(DEPTH))
  );

endmodule

// File: rtl/instr_prefetch.sv
// -----------------------------------------------------------------------------
// instr_prefetch
//   Prefetches sequential instruction words from the EduSoC instruction bus
//   into a small FIFO and hands them to decode with a valid/ready handshake.
//   A redirect flushes the buffer; a bus request already issued cannot be
//   aborted, so its response is drained and dropped (DISCARD) before fetching
//   from the new PC.
//
//   Optional feature macro: INSTR_PREFETCH_ALIGN_CHECK_EN
//     defined   : misaligned REDIRECT_PC raises FETCH_MISALIGNED and parks the
//                 unit in FAULT until an aligned redirect arrives.
//     undefined : REDIRECT_PC[1:0] is ignored, FETCH_MISALIGNED is 0.
//
//   Ports:
//     CPU_CLK, CPU_RES        : clock, synchronous active-high reset
//     INSTR_REQ, INSTR_ADDR   : registered bus request and word address
//     INSTR_VALID, INSTR_RDATA: one-cycle bus response
//     FETCH_VALID/READY       : decode handshake on the FIFO head
//     FETCH_INSTR, FETCH_PC   : head instruction and its PC
//     REDIRECT, REDIRECT_PC   : one-cycle flush and refetch request
//     FETCH_MISALIGNED        : misaligned redirect fault flag
// -----------------------------------------------------------------------------
module instr_prefetch
  import edusoc_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RES,
  output logic        INSTR_REQ,
  input  logic        INSTR_VALID,
  output logic [31:0] INSTR_ADDR,
  input  logic [31:0] INSTR_RDATA,
  output logic        FETCH_VALID,
  input  logic        FETCH_READY,
  output logic [31:0] FETCH_INSTR,
  output logic [31:0] FETCH_PC,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FETCH_MISALIGNED
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            pend_fault_q, pend_fault_d;

  logic [XLEN-1:0] redir_pc_s;
  logic            redir_mis_s;
  logic            push_s;
  logic            pop_s;
  logic            room_s;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   count_next_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
  assign redir_pc_s  = REDIRECT_PC;
  assign redir_mis_s = (REDIRECT_PC[1:0] != 2'b00);
`else
  assign redir_pc_s  = REDIRECT_PC & WORD_MASK;
  assign redir_mis_s = 1'b0;
`endif

  // A redirect voids both the response of this cycle and any pop.
  assign push_s       = (state_q == REQ) && INSTR_VALID && !REDIRECT;
  assign pop_s        = (count_s != '0) && FETCH_READY && !REDIRECT;
  assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);
  assign room_s       = (count_next_s < CW'(DEPTH));

  assign push_entry_s.pc    = fetch_pc_q;
  assign push_entry_s.instr = INSTR_RDATA;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CPU_CLK),
    .rst_i   (CPU_RES),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .flush_i (REDIRECT),
    .count_o (count_s),
    .head_o  (head_s)
  );

  // Next-state logic: redirect handling first, then normal fetch flow.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    pend_fault_d = pend_fault_q;

    if (REDIRECT) begin
      case (state_q)
        REQ, DISCARD: begin
          if (INSTR_VALID) begin
            // Outstanding request completes now; its data is dropped.
            pend_fault_d = 1'b0;
            if (redir_mis_s) begin
              state_d = FAULT;
            end else begin
              fetch_pc_d = redir_pc_s;
              state_d    = REQ;
            end
          end else begin
            // Request still in flight: remember the target, drain first.
            pending_pc_d = redir_pc_s;
            pend_fault_d = redir_mis_s;
            state_d      = DISCARD;
          end
        end
        default: begin
          pend_fault_d = 1'b0;
          if (redir_mis_s) begin
            state_d = FAULT;
          end else begin
            fetch_pc_d = redir_pc_s;
            state_d    = REQ;
          end
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (room_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (INSTR_VALID) begin
            fetch_pc_d = fetch_pc_q + FETCH_STEP;
            state_d    = room_s ? REQ : IDLE;
          end else begin
            state_d = REQ;
          end
        end
        DISCARD: begin
          if (INSTR_VALID) begin
            pend_fault_d = 1'b0;
            if (pend_fault_q) begin
              state_d = FAULT;
            end else begin
              fetch_pc_d = pending_pc_q;
              state_d    = REQ;
            end
          end else begin
            state_d = DISCARD;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Bus outputs are registered from the next state; DISCARD keeps the stale
  // address so it stays stable until the outstanding response arrives.
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == DISCARD);
    addr_d = addr_q;
    if (state_d == REQ) begin
      addr_d = fetch_pc_d & WORD_MASK;
    end else begin
      addr_d = addr_q;
    end
  end

  // Controller state and bus output registers.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RES) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      pend_fault_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      pend_fault_q <= pend_fault_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
    end
  end

`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  // Fault flag follows the alignment of the most recent redirect.
  always_comb begin
    mis_d = mis_q;
    if (REDIRECT) begin
      mis_d = redir_mis_s;
    end else begin
      mis_d = mis_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RES) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign FETCH_MISALIGNED = mis_q;
`else
  assign FETCH_MISALIGNED = 1'b0;
`endif

  assign INSTR_REQ   = req_q;
  assign INSTR_ADDR  = addr_q;
  assign FETCH_VALID = (count_s != '0);
  assign FETCH_INSTR = head_s.instr;
  assign FETCH_PC    = head_s.pc;

endmodule
